// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit frame controller: start, data, optional parity, stop.
// Steps an external serializer with Ser_EN and drives a registered TX line.
module uart_tx_fsm #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [width-1:0] Data,
  input  logic             Data_valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             Ser_data,
  output logic             Ser_EN,
  output logic             Busy,
  output logic             TX_OUT
);
  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] bit_cnt_q;
  logic          par_bit_q;
  logic          par_en_q;
  logic          tx_q;
  logic          tx_d;

  // Line level follows the state one cycle later so TX_OUT never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = Ser_data;
      PARITY:  tx_d = par_bit_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tx_q <= tx_d;
      case (state_q)
        IDLE: begin
          if (Data_valid) begin
            state_q   <= START;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^Data) ^ PAR_TYP;
          end
        end
        START: begin
          state_q   <= DATA;
          bit_cnt_q <= '0;
        end
        DATA: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST) begin
            state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: state_q <= STOP;
        STOP:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ser_EN = (state_q == DATA);
  assign Busy   = (state_q != IDLE);
  assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - scoreboard bench for uart_tx_fsm with a behavioural serializer.
module tb_uart_tx_fsm;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         Reset;
  logic [W-1:0] Data;
  logic         Data_valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         Ser_data;
  logic         Ser_EN;
  logic         Busy;
  logic         TX_OUT;

  int checks   = 0;
  int failures = 0;

  bit exp_q[$];
  int len_q[$];
  bit in_frame = 1'b0;
  int left     = 0;

  uart_tx_fsm #(.width(W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Data       (Data),
    .Data_valid (Data_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Ser_data   (Ser_data),
    .Ser_EN     (Ser_EN),
    .Busy       (Busy),
    .TX_OUT     (TX_OUT)
  );

  always #5 CLK = ~CLK;

  // Serializer partner: loads on an accepted strobe, shifts LSB-first on Ser_EN.
  logic [W-1:0] ser_q;
  always @(posedge CLK or posedge Reset) begin
    if (Reset) ser_q <= '0;
    else if (Data_valid && !Busy) ser_q <= Data;
    else if (Ser_EN) ser_q <= ser_q >> 1;
  end
  assign Ser_data = ser_q[0];

  // Line monitor: a falling line opens a frame, each following bit is popped and compared.
  always @(negedge CLK) begin
    bit exp_bit;
    if (Reset) begin
      exp_q.delete();
      len_q.delete();
      in_frame = 1'b0;
    end else if (in_frame) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_bit queue empty got=%b", TX_OUT);
        in_frame = 1'b0;
      end else begin
        exp_bit = exp_q.pop_front();
        if (TX_OUT !== exp_bit) begin
          failures++;
          $display("FAIL tx_bit t=%0t got=%b exp=%b", $time, TX_OUT, exp_bit);
        end
        left--;
        if (left == 0) in_frame = 1'b0;
      end
    end else if (TX_OUT !== 1'b1) begin
      checks++;
      if (len_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_start t=%0t got=%b exp=1", $time, TX_OUT);
      end else if (TX_OUT !== 1'b0) begin
        failures++;
        $display("FAIL start_bit got=%b exp=0", TX_OUT);
      end else begin
        left = len_q.pop_front() - 1;
        exp_bit = exp_q.pop_front();
        in_frame = (left > 0);
      end
    end
  end

  // Called at the sampling point of cycle 0; returns at the sampling point of cycle 1.
  task automatic drive_frame(input logic [W-1:0] d, input logic pen, input logic ptyp);
    Data       = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_valid = 1'b1;
    exp_q.push_back(1'b0);
    for (int k = 0; k < W; k++) exp_q.push_back(d[k]);
    if (pen) exp_q.push_back(ptyp ? ~(^d) : (^d));
    exp_q.push_back(1'b1);
    len_q.push_back(pen ? W + 3 : W + 2);
    @(negedge CLK);
    Data_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Data = '0; Data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0 || Ser_EN !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got=%b%b%b exp=100", TX_OUT, Busy, Ser_EN);
    end
    Reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0 || Ser_EN !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet n=%0d got=%b%b%b exp=100", n, TX_OUT, Busy, Ser_EN);
      end
    end
  endtask

  task automatic test_parity(input logic [W-1:0] d, input logic ptyp);
    @(negedge CLK);
    drive_frame(d, 1'b1, ptyp);
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) @(negedge CLK);
      checks++;
      if (Busy !== (n <= W + 3)) begin
        failures++;
        $display("FAIL par_busy cycle=%0d got=%b exp=%b", n, Busy, (n <= W + 3));
      end
      checks++;
      if (Ser_EN !== (n >= 2 && n <= W + 1)) begin
        failures++;
        $display("FAIL par_ser_en cycle=%0d got=%b exp=%b", n, Ser_EN, (n >= 2 && n <= W + 1));
      end
      if (n == W + 3) begin
        checks++;
        if (TX_OUT !== (ptyp ? ~(^d) : (^d))) begin
          failures++;
          $display("FAIL par_bit got=%b exp=%b", TX_OUT, (ptyp ? ~(^d) : (^d)));
        end
      end
    end
  endtask

  task automatic test_no_parity();
    @(negedge CLK);
    drive_frame(8'h01, 1'b0, 1'b0);
    for (int n = 1; n <= 13; n++) begin
      if (n > 1) @(negedge CLK);
      checks++;
      if (Busy !== (n <= W + 2)) begin
        failures++;
        $display("FAIL nopar_busy cycle=%0d got=%b exp=%b", n, Busy, (n <= W + 2));
      end
      if (n == W + 3) begin
        checks++;
        if (TX_OUT !== 1'b1) begin
          failures++;
          $display("FAIL nopar_stop got=%b exp=1", TX_OUT);
        end
      end
    end
  endtask

  task automatic test_ignored_strobe();
    int busy_cnt = 0;
    @(negedge CLK);
    drive_frame(8'h00, 1'b1, 1'b0);
    busy_cnt = Busy ? 1 : 0;
    for (int n = 2; n <= 18; n++) begin
      @(negedge CLK);
      if (n == 5) begin
        Data = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b1; Data_valid = 1'b1;
      end else begin
        Data_valid = 1'b0;
      end
      if (n == 8) PAR_TYP = 1'b0;
      if (n == 9) PAR_TYP = 1'b1;
      if (Busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt != W + 3) begin
      failures++;
      $display("FAIL ignore_busy_len got=%0d exp=%0d", busy_cnt, W + 3);
    end
    checks++;
    if (len_q.size() != 0 || in_frame) begin
      failures++;
      $display("FAIL ignore_frame_done got=%0d exp=0", len_q.size());
    end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    drive_frame(8'h5A, 1'b1, 1'b1);
    for (int n = 2; n <= W + 4; n++) @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_free got=%b%b exp=01", Busy, TX_OUT);
    end
    drive_frame(8'hC3, 1'b0, 1'b0);
    checks++;
    if (Busy !== 1'b1 || TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle_gap got=%b%b exp=11", Busy, TX_OUT);
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_start got=%b exp=0", TX_OUT);
    end
    repeat (12) @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || len_q.size() != 0 || in_frame) begin
      failures++;
      $display("FAIL b2b_done got=%b/%0d exp=0/0", Busy, len_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK);
    drive_frame(8'h96, 1'b1, 1'b0);
    repeat (5) @(negedge CLK);
    checks++;
    if (Ser_EN !== 1'b1) begin
      failures++;
      $display("FAIL midrst_in_data got=%b exp=1", Ser_EN);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || Ser_EN !== 1'b0 || TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL midrst_async got=%b%b%b exp=001", Busy, Ser_EN, TX_OUT);
    end
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    drive_frame(8'h3C, 1'b1, 1'b1);
    repeat (14) @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || len_q.size() != 0 || in_frame) begin
      failures++;
      $display("FAIL midrst_new_frame got=%b/%0d exp=0/0", Busy, len_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_parity(8'hA5, 1'b0);
    test_parity(8'hA5, 1'b1);
    test_parity(8'h37, 1'b0);
    test_no_parity();
    test_ignored_strobe();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0 || in_frame) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
